hash_byte_feeder: RTL and testbench

- Producer-side streamer for the full_hash core.
- A host loads a message of up to DEPTH bytes into an internal buffer and pulses go.
- The block pulses start, transfers each byte over the four-phase F_dr/F_rtr handshake, signals End_of_File, then captures R_h when H_ready rises.
- It replaces bench-driven stimulus with synthesizable logic at the hash core's input.

---
 rtl/hash_byte_feeder.sv | 138 +++++++++++++
 tb/tb_hash_byte_feeder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hash_byte_feeder.sv
// Producer-side streamer for the full_hash core: buffers a host message, then
// replays it over the four-phase F_dr/F_rtr handshake and captures the result.
module hash_byte_feeder #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clear,
    input  logic          go,
    output logic          start,
    output logic [7:0]    Byte,
    output logic          F_dr,
    output logic          End_of_File,
    input  logic          F_rtr,
    input  logic          H_ready,
    input  logic [0:31]   R_h,
    output logic [31:0]   hash_out,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   len,
    output logic          ovf,
    output logic          err
);
    localparam int          CW   = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, REQ, ACK_LO, EOF_RDY, EOF_HOLD, WAIT_H, DONE
    } state_t;

    state_t        state, state_n;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] idx, idx_n;
    logic [AW:0]   idx_inc;
    logic [CW-1:0] wd_cnt;
    logic          idle, watched, expired, abort, wr_ok;

    assign idle    = (state == IDLE);
    assign watched = (state == REQ) || (state == ACK_LO) || (state == EOF_RDY) ||
                     (state == EOF_HOLD) || (state == WAIT_H);
    assign expired = watched && (wd_cnt == CW'(TIMEOUT - 1));
    assign idx_inc = {1'b0, idx} + {{AW{1'b0}}, 1'b1};
    assign wr_ok   = idle && !clear && wr_en && (len != FULL);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        abort   = 1'b0;
        case (state)
            IDLE:     if (go) begin
                          state_n = START;
                          idx_n   = '0;
                      end
            START:    state_n = (len != '0) ? REQ : EOF_RDY;
            REQ:      if (F_rtr) state_n = ACK_LO;
            ACK_LO:   if (!F_rtr) begin
                          idx_n   = idx_inc[AW-1:0];
                          state_n = (idx_inc == len) ? EOF_RDY : REQ;
                      end
            EOF_RDY:  if (F_rtr) state_n = EOF_HOLD;
            EOF_HOLD: if (!F_rtr) state_n = WAIT_H;
            WAIT_H:   if (H_ready) state_n = DONE;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
        // A handshake that completes on the last allowed cycle wins over the watchdog.
        if (expired && state_n == state) begin
            state_n = IDLE;
            abort   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            wd_cnt <= '0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            wd_cnt <= (state_n != state) ? '0 : wd_cnt + CW'(1);
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start       <= 1'b0;
            Byte        <= '0;
            F_dr        <= 1'b0;
            End_of_File <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hash_out    <= '0;
        end else begin
            start       <= (state_n == START);
            F_dr        <= (state_n == REQ);
            End_of_File <= (state_n == EOF_HOLD);
            busy        <= (state_n != IDLE);
            done        <= (state_n == DONE);
            if (state_n == REQ)
                Byte <= mem[idx_n];
            // R_h is [0:31]; a plain copy lands R_h[0] on hash_out[31].
            if (state == WAIT_H && state_n == DONE)
                hash_out <= R_h;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len <= '0;
            ovf <= 1'b0;
            err <= 1'b0;
        end else begin
            if (idle && clear) begin
                len <= '0;
                ovf <= 1'b0;
                err <= 1'b0;
            end else if (idle && wr_en) begin
                if (len != FULL)
                    len <= len + {{AW{1'b0}}, 1'b1};
                else
                    ovf <= 1'b1;
            end
            if (abort)
                err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[len[AW-1:0]] <= wr_data;
    end
endmodule

// File: tb/tb_hash_byte_feeder.sv
// Directed + randomized checks of hash_byte_feeder against a queue-based
// message model and a scripted four-phase core responder.
module tb_hash_byte_feeder;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        wr_en = 1'b0, clear = 1'b0, go = 1'b0, go_t = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        F_rtr = 1'b0, rtr_t = 1'b0, H_ready = 1'b0;
    logic [0:31] R_h = '0;

    logic        start, F_dr, End_of_File, busy, done, ovf, err;
    logic [7:0]  Byte;
    logic [31:0] hash_out;
    logic [AW:0] len;

    logic        t_start, t_F_dr, t_eof, t_busy, t_done, t_ovf, t_err;
    logic [7:0]  t_Byte;
    logic [31:0] t_hash;
    logic [AW:0] t_len;

    hash_byte_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clear(clear), .go(go),
        .start(start), .Byte(Byte), .F_dr(F_dr), .End_of_File(End_of_File),
        .F_rtr(F_rtr), .H_ready(H_ready), .R_h(R_h), .hash_out(hash_out),
        .busy(busy), .done(done), .len(len), .ovf(ovf), .err(err));

    hash_byte_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(16)) dut_t (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clear(clear), .go(go_t),
        .start(t_start), .Byte(t_Byte), .F_dr(t_F_dr), .End_of_File(t_eof),
        .F_rtr(rtr_t), .H_ready(H_ready), .R_h(R_h), .hash_out(t_hash),
        .busy(t_busy), .done(t_done), .len(t_len), .ovf(t_ovf), .err(t_err));

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int n_start = 0, n_fdr = 0, n_eof = 0, n_done = 0, t_fdr_hi = 0, t_done_n = 0;
    logic p_start = 1'b0, p_fdr = 1'b0, p_eof = 1'b0, p_done = 1'b0;

    // Edge counters for the main DUT, cycle counters for the short-timeout one.
    always @(negedge clk) begin
        if (start && !p_start) n_start++;
        if (F_dr && !p_fdr) n_fdr++;
        if (End_of_File && !p_eof) n_eof++;
        if (done && !p_done) n_done++;
        if (t_F_dr) t_fdr_hi++;
        if (t_done) t_done_n++;
        p_start = start; p_fdr = F_dr; p_eof = End_of_File; p_done = done;
    end

    logic [7:0] mbuf[$];
    bit         mdl_ovf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0: return F_dr;
            1: return End_of_File;
            2: return start;
            3: return done;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_on(input int which, input logic val, input int lim, input string tag);
        bit ok = 1'b0;
        for (int t = 0; t < lim; t++) begin
            if (sig(which) === val) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk({"wait_", tag}, 64'(ok), 64'd1);
    endtask

    task automatic host_write(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (mbuf.size() < DEPTH) mbuf.push_back(d); else mdl_ovf = 1'b1;
    endtask

    task automatic host_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        mbuf.delete();
        mdl_ovf = 1'b0;
    endtask

    // Plays the hash core for one full run; rst_at >= 0 resets mid-byte.
    task automatic run_msg(input int dly0, input bit go_again, input int rst_at,
                           input bit wr_with_go, input logic [7:0] wb);
        int n, s_start, s_fdr, s_eof, s_done;
        logic [0:31] rh;
        logic [31:0] expv;
        s_start = n_start; s_fdr = n_fdr; s_eof = n_eof; s_done = n_done;
        go = 1'b1;
        if (wr_with_go) begin
            wr_en = 1'b1; wr_data = wb;
            if (mbuf.size() < DEPTH) mbuf.push_back(wb); else mdl_ovf = 1'b1;
        end
        @(negedge clk);
        go = 1'b0; wr_en = 1'b0;
        n = mbuf.size();
        wait_on(2, 1'b1, 4, "start");
        for (int i = 0; i < n; i++) begin
            wait_on(0, 1'b1, 64, "fdr_hi");
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_fdr", 64'(F_dr), 64'd0);
                chk("rst_eof", 64'(End_of_File), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_len", 64'(len), 64'd0);
                F_rtr = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                mbuf.delete();
                mdl_ovf = 1'b0;
                return;
            end
            chk($sformatf("byte%0d", i), 64'(Byte), 64'(mbuf[i]));
            if (i == 0 && dly0 > 0) begin
                repeat (dly0) @(negedge clk);
                chk("fdr_held", 64'(F_dr), 64'd1);
            end else begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            F_rtr = 1'b1;
            wait_on(0, 1'b0, 8, "fdr_lo");
            F_rtr = 1'b0;
            chk($sformatf("hold%0d", i), 64'(Byte), 64'(mbuf[i]));
            if (go_again && i == 4) begin
                go = 1'b1; wr_en = 1'b1; wr_data = 8'hAA;
                @(negedge clk);
                go = 1'b0; wr_en = 1'b0;
            end
            @(negedge clk);
        end
        chk("eof_pre", 64'(End_of_File), 64'd0);
        F_rtr = 1'b1;
        wait_on(1, 1'b1, 8, "eof_hi");
        chk("fdr_in_eof", 64'(F_dr), 64'd0);
        F_rtr = 1'b0;
        wait_on(1, 1'b0, 8, "eof_lo");
        repeat ($urandom_range(1, 5)) @(negedge clk);
        rh = $urandom();
        for (int k = 0; k < 32; k++) expv[31-k] = rh[k];
        R_h = rh; H_ready = 1'b1;
        wait_on(3, 1'b1, 8, "done");
        H_ready = 1'b0;
        chk("hash", 64'(hash_out), 64'(expv));
        repeat (2) @(negedge clk);
        chk("n_start", 64'(n_start - s_start), 64'd1);
        chk("n_fdr", 64'(n_fdr - s_fdr), 64'(n));
        chk("n_eof", 64'(n_eof - s_eof), 64'd1);
        chk("n_done", 64'(n_done - s_done), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        chk("len_kept", 64'(len), 64'(mbuf.size()));
        chk("ovf_end", 64'(ovf), 64'(mdl_ovf));
        chk("err_end", 64'(err), 64'd0);
    endtask

    initial begin
        logic [7:0] ciao [9];
        int s, sd, nr;
        ciao = '{8'h43, 8'h69, 8'h61, 8'h6F, 8'h4D, 8'h6F, 8'h6E, 8'h64, 8'h6F};

        repeat (3) @(negedge clk);
        chk("reset_outs", 64'({start, F_dr, End_of_File, busy, done, ovf, err, len, Byte}), 64'd0);
        chk("reset_hash", 64'(hash_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (ciao[i]) host_write(ciao[i]);
        chk("len_ciao", 64'(len), 64'd9);
        chk("t_len_ciao", 64'(t_len), 64'd9);

        // Short-timeout instance with a core that never answers.
        s = t_fdr_hi; sd = t_done_n;
        go_t = 1'b1;
        @(negedge clk);
        go_t = 1'b0;
        repeat (40) @(negedge clk);
        chk("t_fdr_cycles", 64'(t_fdr_hi - s), 64'd16);
        chk("t_fdr_low", 64'(t_F_dr), 64'd0);
        chk("t_err", 64'(t_err), 64'd1);
        chk("t_busy", 64'(t_busy), 64'd0);
        chk("t_hash", 64'(t_hash), 64'd0);
        chk("t_no_done", 64'(t_done_n - sd), 64'd0);

        run_msg(0, 1'b0, -1, 1'b0, 8'h00);
        run_msg(0, 1'b1, -1, 1'b0, 8'h00);
        run_msg(500, 1'b0, -1, 1'b0, 8'h00);

        host_clear();
        chk("t_err_clr", 64'(t_err), 64'd0);
        chk("len_empty", 64'(len), 64'd0);
        run_msg(0, 1'b0, -1, 1'b0, 8'h00);

        for (int k = 0; k < 17; k++) host_write(8'($urandom()));
        chk("len_full", 64'(len), 64'(mbuf.size()));
        chk("ovf_set", 64'(ovf), 64'(mdl_ovf));
        run_msg(0, 1'b0, -1, 1'b0, 8'h00);
        host_clear();
        chk("len_clr", 64'(len), 64'd0);
        chk("ovf_clr", 64'(ovf), 64'd0);

        for (int it = 0; it < 4; it++) begin
            host_clear();
            nr = $urandom_range(1, DEPTH);
            for (int k = 0; k < nr - 1; k++) host_write(8'($urandom()));
            run_msg(0, 1'b0, -1, 1'b1, 8'($urandom()));
        end

        host_clear();
        foreach (ciao[i]) host_write(ciao[i]);
        run_msg(0, 1'b0, 3, 1'b0, 8'h00);
        @(negedge clk);
        chk("len_after_rst", 64'(len), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
